branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Downstream resolution stage for the `branch` predictor.
- Tracks in-flight predictions (`predicted_branch`) in order and compares each against the actual outcome when it resolves.
- Signals mispredicts and flushes younger in-flight predictions.
- Maintains the 2-bit saturating confidence state that drives the predictor's `branch_condition` input, closing the predict/update loop.

Parameters:
- DEPTH, 4, max in-flight predictions; power of 2, >= 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- pred_valid  input  1  predictor issued a prediction this cycle
- predicted_branch  input  1  prediction from `branch` (1 = taken)
- pred_ready  output  1  tracking queue can accept; equals !full
- res_valid  input  1  oldest in-flight branch resolves this cycle
- actual_taken  input  1  resolved outcome (1 = taken)
- branch_condition  output  2  saturating counter state, fed to `branch`
- mispredict  output  1  one-cycle pulse, registered
- inflight  output  $clog2(DEPTH)+1  current queue occupancy
- branch_count  output  CNT_W  branches resolved since reset
- mispredict_count  output  CNT_W  mispredicts since reset
- res_error  output  1  sticky; set when a resolution arrives with the queue empty

Behaviour:
- Reset is synchronous and active-high: `rst` is sampled on the `clk` rising edge.
- Reset values:
  - queue emptied; inflight=0, pred_ready=1
  - branch_condition=2'b01 (weakly not-taken)
  - mispredict=0, branch_count=0, mispredict_count=0, res_error=0
- Reset mid-operation discards all in-flight entries with no mispredict pulse.
- Queue:
  - Circular FIFO, DEPTH entries x 1 bit, with read/write pointers and an occupancy counter.
  - push = pred_valid & pred_ready.
  - pop = res_valid & (inflight != 0).
  - Pointers wrap modulo DEPTH.
- Resolution, in the cycle where pop is high:
  - Compare head entry vs actual_taken: miss = head ^ actual_taken.
  - At the next edge:
    - mispredict <= miss
    - branch_count += 1
    - mispredict_count += miss
    - Both counters saturate at all-ones; no wrap.
- Confidence update on every pop, using the previous value:
  - actual_taken=1: branch_condition increments, saturating at 2'b11.
  - actual_taken=0: branch_condition decrements, saturating at 2'b00.
  - Updated value is visible the cycle after resolution; latency is 1 cycle.
- Flush on miss:
  - All younger entries are discarded; the queue becomes empty and inflight=0 at the next edge.
  - A push in the same cycle as a mispredicting pop is dropped, since it belongs to the wrong path.
- Simultaneous push and pop without miss:
  - Occupancy unchanged; both pointers advance.
  - At full, pred_ready=0, so no push is possible even if a pop is occurring (pred_ready has no combinational dependence on res_valid).
- res_valid with the queue empty:
  - No pop; counters and branch_condition are unchanged.
  - res_error <= 1, sticky until rst.
  - A push in that cycle proceeds normally.
- pred_valid while !pred_ready: ignored, no state change.
- mispredict is low in every cycle not immediately following a mispredicting pop.

Test Plan:
1. Reset:
   - Stimulus: assert rst 2 cycles.
   - Required: branch_condition=01, inflight=0, pred_ready=1, counts=0, res_error=0.
2. Correct predictions:
   - Stimulus: push predictions 1,1,1; resolve actual 1,1,1.
   - Required: mispredict stays 0; branch_condition 01->10->11->11 (saturates); branch_count=3, mispredict_count=0.
3. Mispredict flush:
   - Stimulus: push 0,1,1 (inflight=3); resolve actual=1 while pred_valid=1.
   - Required: next cycle mispredict=1 for exactly 1 cycle; inflight=0 (same-cycle push dropped); mispredict_count=1; branch_condition 01->10.
4. Full queue:
   - Stimulus: push 4 predictions with no resolves.
   - Required: inflight=4, pred_ready=0; a 5th pred_valid is ignored.
   - Then resolve 1 correctly: inflight=3, pred_ready=1, and the next push is accepted.
5. Underflow:
   - Stimulus: res_valid=1 with the queue empty.
   - Required: res_error=1 and stays 1; branch_count=0; branch_condition=01.
   - Same cycle with pred_valid=1: inflight becomes 1.
6. Decrement saturation and mid-run reset:
   - Stimulus: 3 resolutions with actual=0 from state 01.
   - Required: branch_condition 01->00->00->00.
   - Then push 2 entries and assert rst: inflight=0, mispredict=0, branch_condition=01.

Source files
------------

// File: rtl/branch_resolve.sv
// Resolves in-flight branch predictions in order, flags mispredicts and flushes the wrong path.
// Results and confidence update one cycle after resolution; pred_ready = !full, with no dependence on res_valid.
module branch_resolve #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pred_valid,
    input  logic                     predicted_branch,
    output logic                     pred_ready,
    input  logic                     res_valid,
    input  logic                     actual_taken,
    output logic [1:0]               branch_condition,
    output logic                     mispredict,
    output logic [$clog2(DEPTH):0]   inflight,
    output logic [CNT_W-1:0]         branch_count,
    output logic [CNT_W-1:0]         mispredict_count,
    output logic                     res_error
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] FULL = OW'(DEPTH);

    logic [DEPTH-1:0] entries;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [OW-1:0]    occ;
    logic [OW-1:0]    occ_next;
    logic             empty;
    logic             push;
    logic             pop;
    logic             miss;
    logic             keep_push;

    assign empty      = (occ == '0);
    assign pred_ready = (occ != FULL);
    assign push       = pred_valid & pred_ready;
    assign pop        = res_valid & ~empty;
    assign miss       = pop & (entries[rd_ptr] ^ actual_taken);
    // A prediction arriving alongside a mispredict is on the wrong path.
    assign keep_push  = push & ~miss;
    assign inflight   = occ;

    always_comb begin
        occ_next = occ;
        if (miss) begin
            occ_next = '0;
        end else if (keep_push && !pop) begin
            occ_next = occ + OW'(1);
        end else if (pop && !keep_push) begin
            occ_next = occ - OW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entries          <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            occ              <= '0;
            branch_condition <= 2'b01;
            mispredict       <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
            res_error        <= 1'b0;
        end else begin
            occ        <= occ_next;
            mispredict <= miss;

            if (keep_push) begin
                entries[wr_ptr] <= predicted_branch;
                wr_ptr          <= wr_ptr + PW'(1);
            end

            // Flush by collapsing the read pointer onto the write pointer.
            if (miss) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            if (pop) begin
                if (!(&branch_count)) begin
                    branch_count <= branch_count + CNT_W'(1);
                end
                if (miss && !(&mispredict_count)) begin
                    mispredict_count <= mispredict_count + CNT_W'(1);
                end
                if (actual_taken) begin
                    if (branch_condition != 2'b11) begin
                        branch_condition <= branch_condition + 2'd1;
                    end
                end else begin
                    if (branch_condition != 2'b00) begin
                        branch_condition <= branch_condition - 2'd1;
                    end
                end
            end

            if (res_valid && empty) begin
                res_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Randomised and directed stimulus against a queue-based reference model with a resolution scoreboard.
module tb_branch_resolve;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   pred_valid = 1'b0;
    logic                   predicted_branch = 1'b0;
    logic                   pred_ready;
    logic                   res_valid = 1'b0;
    logic                   actual_taken = 1'b0;
    logic [1:0]             branch_condition;
    logic                   mispredict;
    logic [$clog2(DEPTH):0] inflight;
    logic [CNT_W-1:0]       branch_count;
    logic [CNT_W-1:0]       mispredict_count;
    logic                   res_error;

    branch_resolve #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .predicted_branch(predicted_branch), .pred_ready(pred_ready),
        .res_valid(res_valid), .actual_taken(actual_taken),
        .branch_condition(branch_condition), .mispredict(mispredict), .inflight(inflight),
        .branch_count(branch_count), .mispredict_count(mispredict_count), .res_error(res_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit miss;
        int bcount;
        int mcount;
    } rec_t;

    rec_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model state, updated right after each rising edge.
    bit   mq[$];
    int   m_bc = 1;
    int   m_bcount = 0;
    int   m_mcount = 0;
    bit   m_err = 0;
    bit   m_in_reset = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit pv, input bit pb, input bit rv, input bit at);
        bit   ready;
        bit   miss;
        bit   head;
        rec_t rec;
        m_in_reset = r;
        if (r) begin
            mq.delete();
            m_bc = 1; m_bcount = 0; m_mcount = 0; m_err = 0;
            return;
        end
        ready = (mq.size() < DEPTH);
        miss  = 0;
        if (rv && mq.size() == 0) m_err = 1;
        if (rv && mq.size() > 0) begin
            head = mq.pop_front();
            miss = (head != at);
            m_bcount = (m_bcount < CMAX) ? m_bcount + 1 : CMAX;
            if (miss) m_mcount = (m_mcount < CMAX) ? m_mcount + 1 : CMAX;
            m_bc = at ? ((m_bc < 3) ? m_bc + 1 : 3) : ((m_bc > 0) ? m_bc - 1 : 0);
            if (miss) mq.delete();
            rec.miss = miss; rec.bcount = m_bcount; rec.mcount = m_mcount;
            sb.push_back(rec);
        end
        if (pv && ready && !miss) mq.push_back(pb);
    endtask

    task automatic step(input bit r, input bit pv, input bit pb, input bit rv, input bit at);
        rst = r; pred_valid = pv; predicted_branch = pb; res_valid = rv; actual_taken = at;
        @(posedge clk);
        model_update(r, pv, pb, rv, at);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
    endtask

    // Monitor: per-cycle state checks plus scoreboard pop on every observed resolution.
    initial begin
        int   last = 0;
        rec_t rec;
        forever begin
            @(negedge clk);
            chk("inflight", int'(inflight), mq.size());
            chk("pred_ready", int'(pred_ready), (mq.size() < DEPTH) ? 1 : 0);
            chk("branch_condition", int'(branch_condition), m_bc);
            chk("res_error", int'(res_error), int'(m_err));
            if (m_in_reset) begin
                chk("reset_branch_count", int'(branch_count), 0);
                chk("reset_mispredict_count", int'(mispredict_count), 0);
                chk("reset_mispredict", int'(mispredict), 0);
                last = 0;
            end else if (int'(branch_count) != last) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resolution", int'(branch_count), last);
                end else begin
                    rec = sb.pop_front();
                    chk("mispredict", int'(mispredict), int'(rec.miss));
                    chk("branch_count", int'(branch_count), rec.bcount);
                    chk("mispredict_count", int'(mispredict_count), rec.mcount);
                end
                last = int'(branch_count);
            end else begin
                chk("mispredict_idle", int'(mispredict), 0);
            end
        end
    end

    initial begin
        // Reset
        do_reset();
        idle(1);
        // Correct predictions, confidence saturates high
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
        idle(2);
        // Mispredict flush with a same-cycle push
        do_reset();
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 1);
        idle(3);
        // Full queue, ignored push, then pop frees a slot
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 1, 0, 0, 0);
        idle(2);
        // Underflow, alone and with a push
        do_reset();
        step(0, 0, 0, 1, 0);
        idle(2);
        step(0, 1, 0, 1, 1);
        idle(2);
        // Decrement saturation then mid-run reset
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        do_reset();
        idle(2);
        // Random traffic, light then heavy resolution rates
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 1500; i++) begin
                bit r, pv, pb, rv, at;
                r  = ($urandom_range(0, 299) == 0);
                pv = ($urandom_range(0, 99) < 60);
                pb = $urandom_range(0, 1);
                rv = ($urandom_range(0, 99) < (ph == 0 ? 25 : 55));
                // Mostly resolve consistently with the head to keep the queue populated.
                if (mq.size() > 0 && $urandom_range(0, 99) < 75) at = mq[0];
                else at = $urandom_range(0, 1);
                step(r, pv, pb, rv, at);
            end
        end
        idle(3);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
